instr_fetch_unit: RTL and testbench

//  Fetches 16-bit instructions from the 8-bit-wide byte-addressed program memory, two bytes per instruction.

---
 rtl/instr_fetch_unit.sv | 120 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: assembles big-endian 16-bit instructions from an 8-bit program memory
// and hands them downstream over valid/ready, with branch redirect and boundary halt.
module instr_fetch_unit #(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_ack,
    output logic [15:0]       instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              halt,
    output logic              busy,
    output logic [1:0]        dbg_state
);

    // Handshake: a transfer happens on a rising edge where instr_valid & instr_ready are both 1;
    // instr/instr_pc stay frozen while instr_valid=1 and instr_ready=0, unless redirect is pulsed.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FETCH_HI = 2'd1,
        FETCH_LO = 2'd2,
        HOLD     = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [7:0]        hi_q, hi_d;
    logic [7:0]        lo_q, lo_d;
    logic [ADDR_W-1:0] mem_addr_q;
    logic              mem_rd_q;
    logic [15:0]       instr_q;
    logic [ADDR_W-1:0] instr_pc_q;
    logic              instr_valid_q;
    logic              busy_q;

    // Redirect overrides everything, including a same-cycle ack or handshake.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        if (redirect) begin
            pc_d    = redirect_pc;
            hi_d    = '0;
            lo_d    = '0;
            state_d = halt ? IDLE : FETCH_HI;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!halt) state_d = FETCH_HI;
                end
                FETCH_HI: begin
                    if (mem_ack) begin
                        hi_d    = mem_rdata;
                        state_d = FETCH_LO;
                    end
                end
                FETCH_LO: begin
                    if (mem_ack) begin
                        lo_d    = mem_rdata;
                        state_d = HOLD;
                    end
                end
                HOLD: begin
                    if (instr_ready) begin
                        pc_d    = pc_q + ADDR_W'(2);
                        state_d = halt ? IDLE : FETCH_HI;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            hi_q          <= '0;
            lo_q          <= '0;
            mem_rd_q      <= 1'b0;
            mem_addr_q    <= RESET_PC;
            instr_q       <= '0;
            instr_pc_q    <= RESET_PC;
            instr_valid_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            hi_q          <= hi_d;
            lo_q          <= lo_d;
            mem_rd_q      <= (state_d == FETCH_HI) || (state_d == FETCH_LO);
            mem_addr_q    <= (state_d == FETCH_LO) ? pc_d + ADDR_W'(1) : pc_d;
            instr_valid_q <= (state_d == HOLD);
            busy_q        <= (state_d != IDLE);
            if ((state_d == HOLD) && (state_q != HOLD)) begin
                instr_q    <= {hi_d, lo_d};
                instr_pc_q <= pc_d;
            end
        end
    end

    assign mem_addr    = mem_addr_q;
    assign mem_rd      = mem_rd_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = instr_valid_q;
    assign busy        = busy_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios followed by randomized traffic, all checked against
// a program-counter/memory reference model.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  mem_addr;
    logic        mem_rd;
    logic [7:0]  mem_rdata = 8'h00;
    logic        mem_ack = 1'b0;
    logic [15:0] instr;
    logic [7:0]  instr_pc;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic        redirect = 1'b0;
    logic [7:0]  redirect_pc = 8'h00;
    logic        halt = 1'b0;
    logic        busy;
    logic [1:0]  dbg_state;

    instr_fetch_unit #(.ADDR_W(8), .RESET_PC(8'h00)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt), .busy(busy),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [256];
    logic [7:0] exp_pc;
    int         n_checks = 0;
    int         n_bad = 0;
    int         n_xfer = 0;
    int         cnt = 0;
    int         wait_n = 0;
    bit         rand_wait = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Memory model: ack after wait_n idle cycles of a request; junk data when not acking.
    task automatic mem_respond();
        if (mem_ack) begin
            cnt = 0;
            if (rand_wait) wait_n = $urandom_range(0, 2);
        end
        if (mem_rd && cnt >= wait_n) begin
            mem_ack   = 1'b1;
            mem_rdata = mem[mem_addr];
        end else begin
            mem_ack   = 1'b0;
            mem_rdata = 8'($urandom);
            if (mem_rd) cnt++;
            else cnt = 0;
        end
    endtask

    // One clock: score the handshake about to happen, advance the model, then check the result.
    task automatic tick();
        logic       xfer;
        logic       hold_pend;
        logic       wait_pend;
        logic [15:0] hold_instr;
        logic [7:0] hold_pc;
        logic [7:0] wait_addr;
        logic [7:0] p1;
        xfer = instr_valid && instr_ready;
        if (xfer) begin
            p1 = exp_pc + 8'd1;
            check("xfer_instr", 32'(instr), 32'({mem[exp_pc], mem[p1]}));
            check("xfer_pc", 32'(instr_pc), 32'(exp_pc));
            n_xfer++;
        end
        hold_pend  = instr_valid && !instr_ready && !redirect;
        hold_instr = instr;
        hold_pc    = instr_pc;
        wait_pend  = mem_rd && !mem_ack && !redirect;
        wait_addr  = mem_addr;
        if (redirect) exp_pc = redirect_pc;
        else if (xfer) exp_pc = exp_pc + 8'd2;
        @(posedge clk);
        @(negedge clk);
        if (hold_pend) begin
            check("hold_valid", 32'(instr_valid), 32'd1);
            check("hold_instr", 32'(instr), 32'(hold_instr));
            check("hold_pc", 32'(instr_pc), 32'(hold_pc));
        end
        if (wait_pend) begin
            check("wait_rd", 32'(mem_rd), 32'd1);
            check("wait_addr", 32'(mem_addr), 32'(wait_addr));
        end
        if (mem_rd) check("fetch_addr", 32'((mem_addr == exp_pc) || (mem_addr == 8'(exp_pc + 8'd1))), 32'd1);
        mem_respond();
    endtask

    task automatic wait_valid(input int max_cycles);
        int n;
        n = 0;
        while (!instr_valid && n < max_cycles) begin
            tick();
            n++;
        end
        if (!instr_valid) check("valid_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rd"}, 32'(mem_rd), 32'd0);
        check({tag, "_addr"}, 32'(mem_addr), 32'h00);
        check({tag, "_instr"}, 32'(instr), 32'h0000);
        check({tag, "_ipc"}, 32'(instr_pc), 32'h00);
        check({tag, "_valid"}, 32'(instr_valid), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int n;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        mem[8'h00] = 8'hA5;
        mem[8'h01] = 8'h3C;
        mem[8'hFE] = 8'h12;
        mem[8'hFF] = 8'h34;
        exp_pc = 8'h00;

        @(negedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // Zero-wait first fetch: valid in the third cycle after release.
        tick();
        check("t1_rd", 32'(mem_rd), 32'd1);
        check("t1_addr_hi", 32'(mem_addr), 32'h00);
        tick();
        check("t1_addr_lo", 32'(mem_addr), 32'h01);
        check("t1_busy", 32'(busy), 32'd1);
        tick();
        check("t1_valid", 32'(instr_valid), 32'd1);
        check("t1_instr", 32'(instr), 32'hA53C);
        check("t1_pc", 32'(instr_pc), 32'h00);

        // Downstream stall for five cycles.
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t2_instr", 32'(instr), 32'hA53C);
            check("t2_rd", 32'(mem_rd), 32'd0);
        end
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        check("t2_next_addr", 32'(mem_addr), 32'h02);

        // Redirect to the top of memory; the instruction wraps.
        redirect = 1'b1;
        redirect_pc = 8'hFE;
        tick();
        redirect = 1'b0;
        check("t3_addr", 32'(mem_addr), 32'hFE);
        wait_valid(20);
        check("t3_instr", 32'(instr), 32'h1234);
        check("t3_pc", 32'(instr_pc), 32'hFE);
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        check("t3_wrap_addr", 32'(mem_addr), 32'h00);

        // Redirect while the low byte is being acked.
        tick();
        check("t4_addr_lo", 32'(mem_addr), 32'h01);
        redirect = 1'b1;
        redirect_pc = 8'h40;
        tick();
        redirect = 1'b0;
        check("t4_valid", 32'(instr_valid), 32'd0);
        check("t4_addr", 32'(mem_addr), 32'h40);
        wait_valid(20);
        check("t4_pc", 32'(instr_pc), 32'h40);
        check("t4_instr", 32'(instr), 32'({mem[8'h40], mem[8'h41]}));

        // Three wait states per byte.
        wait_n = 3;
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        n = 0;
        while (!instr_valid && n < 20) begin
            tick();
            n++;
        end
        check("t5_latency", 32'(n), 32'd8);
        check("t5_instr", 32'(instr), 32'({mem[8'h42], mem[8'h43]}));
        check("t5_pc", 32'(instr_pc), 32'h42);

        // Halt raised during a fetch lets that instruction finish, then idles.
        wait_n = 0;
        instr_ready = 1'b1;
        tick();
        halt = 1'b1;
        wait_valid(20);
        tick();
        instr_ready = 1'b0;
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_rd", 32'(mem_rd), 32'd0);
        check("t6_valid", 32'(instr_valid), 32'd0);
        tick();
        tick();
        check("t6_idle_busy", 32'(busy), 32'd0);
        halt = 1'b0;
        tick();
        check("t6_restart_addr", 32'(mem_addr), 32'h46);
        check("t6_restart_rd", 32'(mem_rd), 32'd1);
        tick();
        check("t6_lo_addr", 32'(mem_addr), 32'h47);

        // Asynchronous reset in the middle of FETCH_LO.
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("areset");
        mem_ack = 1'b0;
        cnt = 0;
        exp_pc = 8'h00;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized traffic with wait states, stalls, redirects and halts.
        rand_wait = 1;
        for (int i = 0; i < 3000; i++) begin
            instr_ready = ($urandom_range(0, 3) != 0);
            redirect    = ($urandom_range(0, 15) == 0);
            redirect_pc = 8'($urandom);
            halt        = ($urandom_range(0, 7) == 0);
            tick();
        end
        redirect = 1'b0;
        halt = 1'b0;
        check("progress", 32'(n_xfer >= 50), 32'd1);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
